// File: rtl/thermo_stim_capture.sv
// Thermometer-sequence stimulus driver and per-step response capture for 4-input circuits.
// Optional self-check against an expected response word: define THERMO_STIM_CHECK_EN.
module thermo_stim_capture #(
  parameter int unsigned DWELL = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_i,
  output logic       drv_m,
  output logic       drv_r,
  output logic       drv_l,
  input  logic       e_in,
  output logic       busy,
  output logic       done,
  output logic [4:0] resp,
  output logic [2:0] step
`ifdef THERMO_STIM_CHECK_EN
  ,
  input  logic [4:0] expect_resp,
  output logic       mismatch
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);
  localparam logic [2:0]       StepLast = 3'd4;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       step_q;
  logic [4:0]       resp_q;
  logic [3:0]       drv_q;
  logic             busy_q;
  logic             done_q;
  logic [4:0]       resp_upd;

  // Lower s bits set; s saturates at 4.
  function automatic logic [3:0] thermo(input logic [2:0] s);
    case (s)
      3'd0:    thermo = 4'b0000;
      3'd1:    thermo = 4'b0001;
      3'd2:    thermo = 4'b0011;
      3'd3:    thermo = 4'b0111;
      default: thermo = 4'b1111;
    endcase
  endfunction

  // resp is cleared on start, so OR-ing in the current step's sample is enough.
  always_comb begin
    resp_upd = resp_q | (5'(e_in) << step_q);
  end

`ifdef THERMO_STIM_CHECK_EN
  logic [4:0] expect_q;
  logic       mismatch_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      step_q     <= '0;
      resp_q     <= '0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef THERMO_STIM_CHECK_EN
      expect_q   <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            step_q     <= '0;
            resp_q     <= '0;
            drv_q      <= thermo(3'd0);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef THERMO_STIM_CHECK_EN
            expect_q   <= expect_resp;
            mismatch_q <= 1'b0;
`endif
          end
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            cnt_q  <= '0;
            resp_q <= resp_upd;
            if (step_q == StepLast) begin
              state_q    <= StDone;
              step_q     <= '0;
              drv_q      <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`ifdef THERMO_STIM_CHECK_EN
              mismatch_q <= (resp_upd != expect_q);
`endif
            end else begin
              step_q <= step_q + 3'd1;
              drv_q  <= thermo(step_q + 3'd1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign drv_i = drv_q[3];
  assign drv_m = drv_q[2];
  assign drv_r = drv_q[1];
  assign drv_l = drv_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign resp  = resp_q;
  assign step  = step_q;
`ifdef THERMO_STIM_CHECK_EN
  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_thermo_stim_capture.sv
// Randomized bench for thermo_stim_capture: circuit is a 16-entry truth table on {I,M,R,L};
// a cycle-count model of the sweep is compared against the DUT every cycle.
module tb_thermo_stim_capture;
  localparam int DWELL = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       drv_i, drv_m, drv_r, drv_l;
  logic       e_in;
  logic       busy, done;
  logic [4:0] resp;
  logic [2:0] step;
  logic [15:0] tt;
`ifdef THERMO_STIM_CHECK_EN
  logic [4:0] expect_resp;
  logic       mismatch;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign e_in = tt[{drv_i, drv_m, drv_r, drv_l}];

  thermo_stim_capture #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .drv_i (drv_i),
    .drv_m (drv_m),
    .drv_r (drv_r),
    .drv_l (drv_l),
    .e_in  (e_in),
    .busy  (busy),
    .done  (done),
    .resp  (resp),
    .step  (step)
`ifdef THERMO_STIM_CHECK_EN
    ,
    .expect_resp (expect_resp),
    .mismatch    (mismatch)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: time since the first RUN cycle determines everything.
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  int       m_c = 0;
  bit [4:0] m_resp = '0;
  bit [4:0] m_exp = '0;

  function automatic bit [3:0] therm_vec(input int s);
    return 4'((1 << s) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_c = 0; m_resp = '0;
    end else if (m_busy) begin
      if (m_c % DWELL == DWELL - 1) m_resp[m_c / DWELL] = tt[therm_vec(m_c / DWELL)];
      m_c++;
      if (m_c == 5 * DWELL) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_busy = 1'b1; m_done = 1'b0; m_c = 0; m_resp = '0;
`ifdef THERMO_STIM_CHECK_EN
      m_exp = expect_resp;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("resp", 32'(resp), 32'(m_resp));
      check("step", 32'(step), m_busy ? 32'(m_c / DWELL) : 32'd0);
      check("drv", 32'({drv_i, drv_m, drv_r, drv_l}),
            m_busy ? 32'(therm_vec(m_c / DWELL)) : 32'd0);
`ifdef THERMO_STIM_CHECK_EN
      check("mismatch", 32'(mismatch), 32'(m_done && (m_resp != m_exp)));
`endif
    end
  end

  // Pulse start, optionally pulse it again poke cycles later; returns cycles to done.
  task automatic run_sweep(input logic [15:0] t, input logic [4:0] ex, input int poke,
                           output int len);
    @(posedge clk); #1;
    tt = t;
`ifdef THERMO_STIM_CHECK_EN
    expect_resp = ex;
`else
    if (ex != 5'd0) tt = t;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    len = 0;
    while (len < 200) begin
      @(posedge clk); #1;
      len++;
      start = 1'b0;
      if (len == poke) start = 1'b1;
      if (done) break;
    end
    if (!done) check("sweep_timeout", 32'(len), 32'(5 * DWELL));
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst_n = 1'b0;
    start = 1'b0;
    tt    = 16'h8000;
`ifdef THERMO_STIM_CHECK_EN
    expect_resp = '0;
`endif
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_resp", 32'(resp), 32'd0);

    // AND circuit
    run_sweep(16'h8000, 5'b10000, -1, len);
    check("and_len", 32'(len), 32'd100);
    check("and_resp", 32'(resp), 32'b10000);
    check("and_model", 32'(m_resp), 32'b10000);
`ifdef THERMO_STIM_CHECK_EN
    check("and_mismatch0", 32'(mismatch), 32'd0);
`endif
    repeat (5) @(posedge clk);

    // OR circuit, rerun from DONE
    run_sweep(16'hFFFE, 5'b10001, -1, len);
    check("or_len", 32'(len), 32'd100);
    check("or_resp", 32'(resp), 32'b11110);
    check("or_model", 32'(m_resp), 32'b11110);
`ifdef THERMO_STIM_CHECK_EN
    check("or_mismatch1", 32'(mismatch), 32'd1);
`endif

    // start during step 2 is ignored
    run_sweep(16'h8000, 5'b10001, 2 * DWELL + 5, len);
    check("poke_len", 32'(len), 32'd100);
    check("poke_resp", 32'(resp), 32'b10000);
`ifdef THERMO_STIM_CHECK_EN
    check("and_mismatch1", 32'(mismatch), 32'd1);
`endif

    // start coinciding with completion is ignored
    run_sweep(16'hFFFE, 5'b0, 99, len);
    check("coinc_len", 32'(len), 32'd100);
    repeat (3) @(posedge clk);
    #1;
    check("coinc_done_held", 32'(done), 32'd1);
    check("coinc_busy", 32'(busy), 32'd0);

    // reset during step 3
    @(posedge clk); #1;
    tt = 16'hFFFE;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3 * DWELL + 3) @(posedge clk);
    #1;
    check("pre_rst_step", 32'(step), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_drv", 32'({drv_i, drv_m, drv_r, drv_l}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_sweep(16'h8000, 5'b10000, -1, len);
    check("post_rst_len", 32'(len), 32'd100);
    check("post_rst_resp", 32'(resp), 32'b10000);

    // random circuits
    for (int i = 0; i < 8; i++) begin
      run_sweep(16'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 
                int'($urandom_range(1, 99)) : -1, len);
      check("rand_len", 32'(len), 32'd100);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
